multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multi-cycle RV32I datapath; it drives the ALU's ALUControl/SrcA/SrcB selects.
//  Decodes op/funct3/funct7b5 of the latched instruction, sequences fetch/decode/execute/memory/writeback,
//  and generates every datapath enable. Consumes the ALU Zero flag for branch resolution.
// PARAMETERS
//  ALUCTRL_W  3  width of ALUControl; fixed to the ALU encoding
//  STATE_W    4  width of the FSM state register
// PORTS
//  clk        in   1  single clock, rising edge
//  reset      in   1  synchronous, active-high
//  op         in   7  instr[6:0]
//  funct3     in   3  instr[14:12]
//  funct7b5   in   1  instr[30]
//  Zero       in   1  ALU result == 0
//  PCWrite    out  1  PC register enable
//  AdrSrc     out  1  memory address: 0=PC, 1=ALUOut
//  MemWrite   out  1  data memory write enable
//  IRWrite    out  1  instruction/OldPC register enable
//  ResultSrc  out  2  00=ALUOut 01=Data 10=ALUResult
//  ALUSrcA    out  2  00=PC 01=OldPC 10=A
//  ALUSrcB    out  2  00=WriteData 01=ImmExt 10=const 4
//  ImmSrc     out  2  00=I 01=S 10=B 11=J (combinational from op)
//  RegWrite   out  1  register file write enable
//  ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu
//  Illegal    out  1  one-cycle pulse on unsupported instruction
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
//  - Moore outputs from state; PCWrite = PCUpdate | (Branch & taken); only the taken term depends on Zero.
//  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCUpdate=1 -> DECODE.
//  - DECODE: SrcA=01, SrcB=01, add (branch target into ALUOut).
//    Next state by op: lw 0000011/sw 0100011 -> MEMADR, R 0110011 -> EXECUTER, I-ALU 0010011 -> EXECUTEI,
//    branch 1100011 -> BRANCH, jal 1101111 -> JAL.
//    Any other op, or R/I with funct3 001/101: Illegal=1, -> FETCH.
//  - MEMADR: SrcA=10, SrcB=01, add -> MEMREAD (lw) or MEMWRITE (sw).
//  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
//  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  - MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
//  - EXECUTER: SrcA=10, SrcB=00, funct decode. EXECUTEI: SrcA=10, SrcB=01, funct decode. Both -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//  - JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCUpdate=1 -> ALUWB.
//  - BRANCH: SrcA=10, SrcB=00, ResultSrc=00, Branch=1.
//    beq(000): sub, taken=Zero. bne(001): sub, taken=!Zero. -> FETCH.
//  - Funct decode: 000 -> sub iff op[5]&funct7b5, else add; 010->110; 011->111; 100->100; 110->011; 111->010.
//  - Latency: lw 5 cycles, sw/R/I/jal 4, branch 3, illegal 2 (FETCH+DECODE).
//  - Reset: state <= FETCH at the next edge. While reset=1: PCWrite, IRWrite, MemWrite, RegWrite, Illegal = 0.
//    Other outputs follow the state. Reset mid-instruction abandons it with no partial write.
//  - Branch with an unsupported funct3: no PC update, -> FETCH, Illegal=0.
//  - Undriven selects: 00. Unused ALUControl: 000.
// CONFIGURATION
//  - BRANCH_CMP_EN defined: BRANCH also decodes
//    blt(100): 110, taken=!Zero;  bge(101): 110, taken=Zero;
//    bltu(110): 111, taken=!Zero; bgeu(111): 111, taken=Zero.
//  - Undefined: funct3 1xx branches are not taken (PCWrite=0) and return to FETCH.
// STRUCTURE
//  - riscv_ctrl_pkg: state encoding, opcode constants, ALUControl codes, mux-select codes.
//  - Sub-module alu_ctrl_dec (combinational): ALUOp/funct3/funct7b5/op5 -> ALUControl.
//    The FSM, ImmSrc decode and PCWrite logic stay in the top.
// TESTING
//  1. add: op=0110011 f3=000 f7b5=0 -> FETCH,DECODE,EXECUTER(ALUControl=000),ALUWB(RegWrite=1); 4 cycles.
//     Same with f7b5=1 -> 001.
//  2. lw: op=0000011 -> MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1; next FETCH at cycle 6.
//     sw: op=0100011 -> MemWrite=1 only in cycle 4.
//  3. beq: f3=000, Zero=1 -> PCWrite=1 in BRANCH, ALUControl=001. Zero=0 -> PCWrite=0.
//     bne inverts both cases.
//  4. I-ALU: op=0010011 f3=110 -> ALUControl=011, SrcB=01.
//     f3=001 -> Illegal=1 in DECODE, RegWrite never 1, FETCH next.
//  5. Reset: reset=1 while in MEMADR for lw -> next state FETCH; MemWrite/RegWrite stay 0.
//     Release -> IRWrite=1 in the first cycle.
//  6. BRANCH_CMP_EN: blt f3=100, Zero=0 -> ALUControl=110, PCWrite=1.
//     Without the macro: PCWrite=0, 3 cycles.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALUControl codes and datapath mux selects.
package riscv_ctrl_pkg;

  localparam int ALUCTRL_W = 3;
  localparam int STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  // Shift encodings (funct3 001/101) decode as Illegal for R/I-type.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields / ALU flag in, datapath controls out, between the
// multi-cycle controller (slave) and whatever drives the instruction (master).
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic                 RegWrite;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 Illegal;

  modport master (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );

  modport slave (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUControl decode from ALUOp/funct3/funct7b5/op[5].
// BRANCH_CMP_EN adds the signed/unsigned compare branches (blt/bge/bltu/bgeu).
module alu_ctrl_dec
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e              alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_control = ALU_SUB;
`ifdef BRANCH_CMP_EN
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
`endif
          default:        alu_control = ALU_ADD;
        endcase
      end
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi ignores funct7b5.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath; only PCWrite's branch
// term looks at Zero. Optional macro BRANCH_CMP_EN enables blt/bge/bltu/bgeu.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic       pc_update, branch, taken;
  logic       ir_write, mem_write, reg_write, illegal, adr_src;
  logic [1:0] result_src, src_a, src_b;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_WDATA;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: begin
            illegal = is_shift_f3(bus.funct3);
            state_d = illegal ? S_FETCH : S_EXECUTER;
          end
          OP_ITYPE: begin
            illegal = is_shift_f3(bus.funct3);
            state_d = illegal ? S_FETCH : S_EXECUTEI;
          end
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_REG;
        src_b   = SRCB_IMM;
        state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        src_a   = SRCA_REG;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = SRCA_REG;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        src_a   = SRCA_REG;
        alu_op  = ALUOP_BRANCH;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000: taken = bus.Zero;
      3'b001: taken = ~bus.Zero;
`ifdef BRANCH_CMP_EN
      3'b100, 3'b110: taken = ~bus.Zero;
      3'b101, 3'b111: taken = bus.Zero;
`endif
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_STORE:  bus.ImmSrc = IMM_S;
      OP_BRANCH: bus.ImmSrc = IMM_B;
      OP_JAL:    bus.ImmSrc = IMM_J;
      default:   bus.ImmSrc = IMM_I;
    endcase
  end

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.ALUControl)
  );

  // Write enables are forced low during reset so an abandoned instruction leaves no trace.
  assign bus.PCWrite   = ~reset & (pc_update | (branch & taken));
  assign bus.IRWrite   = ~reset & ir_write;
  assign bus.MemWrite  = ~reset & mem_write;
  assign bus.RegWrite  = ~reset & reg_write;
  assign bus.Illegal   = ~reset & illegal;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is summarised
// (latency, enable pulse counts, key selects) and compared to an instruction-level model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic bit is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  function automatic int m_latency(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011:             return 5;
      7'b0100011, 7'b1101111: return 4;
      7'b0110011, 7'b0010011: return is_shift(f3) ? 2 : 4;
      7'b1100011:             return 3;
      default:                return 2;
    endcase
  endfunction

  function automatic bit m_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'b000: return z;
      3'b001: return !z;
`ifdef BRANCH_CMP_EN
      3'b100: return !z;
      3'b101: return z;
      3'b110: return !z;
      3'b111: return z;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // ALUControl in the third cycle (execute / address / branch / jal)
  function automatic logic [2:0] m_alu3(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == 7'b1100011) begin
      if (f3 == 3'b000 || f3 == 3'b001) return 3'd1;
`ifdef BRANCH_CMP_EN
      if (f3 == 3'b100 || f3 == 3'b101) return 3'd6;
      if (f3 == 3'b110 || f3 == 3'b111) return 3'd7;
`endif
      return 3'd0;
    end
    if (op == 7'b0110011 || op == 7'b0010011) begin
      case (f3)
        3'b000:  return (op == 7'b0110011 && f7) ? 3'd1 : 3'd0;
        3'b010:  return 3'd6;
        3'b011:  return 3'd7;
        3'b100:  return 3'd4;
        3'b110:  return 3'd3;
        3'b111:  return 3'd2;
        default: return 3'd0;
      endcase
    end
    return 3'd0;
  endfunction

  function automatic logic [1:0] m_srcb3(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0010011: return 2'b01;
      7'b1101111:                         return 2'b10;
      default:                            return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] m_imm(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // ---------------- one instruction, starting in its fetch cycle ----------------
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z);
    int         cyc, lat, pcw, rw, mw, ill, rw_cyc, mw_cyc, e_lat;
    bit         done, e_rw, e_mw, e_ill;
    logic [2:0] alu3;
    logic [1:0] imm2, srcb3, res5;
    logic       adr4;
    string      tg;
    cyc = 1; pcw = 0; rw = 0; mw = 0; ill = 0; rw_cyc = 0; mw_cyc = 0;
    done = 0; alu3 = '0; imm2 = '0; srcb3 = '0; res5 = '0; adr4 = 1'b0;
    tg = $sformatf("op=%b f3=%b f7=%b z=%b", op, f3, f7, z);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    #1;
    check({"fetch_ir ", tg}, 32'(bus.IRWrite), 32'd1);
    while (!done) begin
      pcw += int'(bus.PCWrite);
      ill += int'(bus.Illegal);
      if (bus.RegWrite === 1'b1) begin rw++; rw_cyc = cyc; end
      if (bus.MemWrite === 1'b1) begin mw++; mw_cyc = cyc; end
      if (cyc == 2) imm2 = bus.ImmSrc;
      if (cyc == 3) begin alu3 = bus.ALUControl; srcb3 = bus.ALUSrcB; end
      if (cyc == 4) adr4 = bus.AdrSrc;
      if (cyc == 5) res5 = bus.ResultSrc;
      @(negedge clk); #1;
      cyc++;
      if (bus.IRWrite === 1'b1) done = 1;
      else if (cyc > 10) begin
        done = 1;
        check({"timeout ", tg}, 32'(cyc), 32'd0);
      end
    end
    lat   = cyc - 1;
    e_lat = m_latency(op, f3);
    e_ill = (e_lat == 2);
    e_rw  = (op == 7'b0000011 || op == 7'b1101111 ||
             ((op == 7'b0110011 || op == 7'b0010011) && !is_shift(f3)));
    e_mw  = (op == 7'b0100011);
    check({"latency ", tg}, 32'(lat), 32'(e_lat));
    check({"pcwrite_cnt ", tg}, 32'(pcw),
          32'(1 + int'(op == 7'b1101111) + int'(op == 7'b1100011 && m_taken(f3, z))));
    check({"regwrite_cnt ", tg}, 32'(rw), 32'(e_rw));
    check({"memwrite_cnt ", tg}, 32'(mw), 32'(e_mw));
    check({"illegal_cnt ", tg}, 32'(ill), 32'(e_ill));
    check({"immsrc ", tg}, 32'(imm2), 32'(m_imm(op)));
    if (e_rw) check({"regwrite_last ", tg}, 32'(rw_cyc), 32'(e_lat));
    if (e_mw) check({"memwrite_cyc ", tg}, 32'(mw_cyc), 32'd4);
    if (!e_ill) begin
      check({"alucontrol ", tg}, 32'(alu3), 32'(m_alu3(op, f3, f7)));
      check({"srcb ", tg}, 32'(srcb3), 32'(m_srcb3(op)));
    end
    if (op == 7'b0000011 || op == 7'b0100011) check({"adrsrc ", tg}, 32'(adr4), 32'd1);
    if (op == 7'b0000011) check({"memwb_res ", tg}, 32'(res5), 32'b01);
    $display("[TB] instr %s latency=%0d pcw=%0d rw=%0d mw=%0d ill=%0d alu=%0d",
             tg, lat, pcw, rw, mw, ill, alu3);
  endtask

  logic [6:0] legal_ops [0:5];

  initial begin
    legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
    legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;

    reset = 1'b1;
    bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("rst_srcb_fetch", 32'(bus.ALUSrcB), 32'b10);
    reset = 1'b0;
    #1;
    check("rst_release_ir", 32'(bus.IRWrite), 32'd1);

    // directed
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
    run_instr(7'b0010011, 3'b001, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);

    // reset in the middle of a load (address cycle)
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("midrst_in_memadr_srca", 32'(bus.ALUSrcA), 32'b10);
    reset = 1'b1;
    #1;
    check("midrst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("midrst_regwrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk); #1;
    check("midrst_fetch_srcb", 32'(bus.ALUSrcB), 32'b10);
    check("midrst_irwrite_held", 32'(bus.IRWrite), 32'd0);
    check("midrst_regwrite2", 32'(bus.RegWrite), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_release_ir", 32'(bus.IRWrite), 32'd1);

    // randomized
    for (int i = 0; i < 300; i++) begin
      logic [6:0] rop;
      rop = ($urandom_range(0, 3) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 5)];
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
